overlay_sprite_sched: RTL

// - Schedules lookups into one shared 1-bit sprite bitmap ROM for up to N_SPR on-screen labels (km unit, digits, icons).
// - Sits between the VGA controller (DrawX/DrawY) and the colour mapper.
// - Per pixel: picks the owning sprite, forms the ROM address, and returns a registered pixel_on/pixel_id aligned 2 cycles later.
// - Sprite origins and enables are CPU/game-FSM writable and double-buffered so that updates take effect only at frame start (no tearing).

---
 rtl/overlay_pkg.sv | 27 ++
 rtl/overlay_hit_cmp.sv | 29 ++
 rtl/overlay_sprite_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/overlay_pkg.sv
// Shared sizes and types for the sprite overlay scheduler: slot config record
// and the address format of the shared 1-bit sprite bitmap ROM.
package overlay_pkg;

  localparam int N_SPR = 4;
  localparam int SPR_W = 30;
  localparam int SPR_H = 20;
  localparam int ID_W  = $clog2(N_SPR);

  typedef logic [ID_W-1:0] spr_id_t;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } spr_cfg_t;

  // ROM word address is {slot id, sprite row, sprite column}
  typedef logic [ID_W+9:0] rom_addr_t;

  function automatic rom_addr_t make_rom_addr(input spr_id_t id,
                                              input logic [4:0] row,
                                              input logic [4:0] col);
    return {id, row, col};
  endfunction

endpackage

// File: rtl/overlay_hit_cmp.sv
// Per-slot window test: does the current pixel fall inside this sprite, and
// at which sprite-local row/column.
module overlay_hit_cmp
  import overlay_pkg::*;
(
  input  spr_cfg_t   cfg,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       hit,
  output logic [4:0] row,
  output logic [4:0] col
);

  logic [10:0] x_end;
  logic [10:0] y_end;

  // Right/bottom edges are formed in 11 bits so a sprite near 1023 never wraps to column 0
  assign x_end = {1'b0, cfg.x} + 11'(SPR_W);
  assign y_end = {1'b0, cfg.y} + 11'(SPR_H);

  assign hit = cfg.en
             && (draw_x >= cfg.x) && ({1'b0, draw_x} < x_end)
             && (draw_y >= cfg.y) && ({1'b0, draw_y} < y_end);

  // Offsets are below 32 whenever hit is set, so the low 5 bits of the difference suffice
  assign col = draw_x[4:0] - cfg.x[4:0];
  assign row = draw_y[4:0] - cfg.y[4:0];

endmodule

// File: rtl/overlay_sprite_sched.sv
// Sprite overlay scheduler: double-buffered slot config, fixed-priority hit
// selection, shared ROM lookup and a 2-cycle pixel_on/pixel_id pipeline.
module overlay_sprite_sched
  import overlay_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset,
  input  logic [9:0]      DrawX,
  input  logic [9:0]      DrawY,
  input  logic            pixel_en,
  input  logic            frame_start,
  input  logic            cfg_we,
  input  logic [ID_W-1:0] cfg_idx,
  input  logic [9:0]      cfg_x,
  input  logic [9:0]      cfg_y,
  input  logic            cfg_en,
  output rom_addr_t       rom_addr,
  input  logic            rom_data,
  output logic            pixel_valid,
  output logic            pixel_on,
  output logic [ID_W-1:0] pixel_id
);

  spr_cfg_t   shadow_cfg [N_SPR];
  spr_cfg_t   active_cfg [N_SPR];
  spr_cfg_t   load_cfg   [N_SPR];
  spr_cfg_t   cmp_cfg    [N_SPR];
  spr_cfg_t   new_cfg;

  logic [N_SPR-1:0] hit_vec;
  logic [4:0]       row_arr [N_SPR];
  logic [4:0]       col_arr [N_SPR];

  logic       win_hit;
  spr_id_t    win_id;
  logic [4:0] win_row;
  logic [4:0] win_col;

  logic       s1_valid;
  logic       s1_hit;
  spr_id_t    s1_id;
  logic       fg_bit;

  assign new_cfg = '{en: cfg_en, x: cfg_x, y: cfg_y};

  // The frame-start pixel already sees the freshly loaded config, including a coincident write
  always_comb begin
    for (int i = 0; i < N_SPR; i++) begin
      load_cfg[i] = (cfg_we && (cfg_idx == spr_id_t'(i))) ? new_cfg : shadow_cfg[i];
      cmp_cfg[i]  = frame_start ? load_cfg[i] : active_cfg[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_SPR; i++) shadow_cfg[i] <= '0;
    end else if (cfg_we) begin
      shadow_cfg[cfg_idx] <= new_cfg;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_SPR; i++) active_cfg[i] <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < N_SPR; i++) active_cfg[i] <= load_cfg[i];
    end
  end

  for (genvar g = 0; g < N_SPR; g++) begin : g_slot
    overlay_hit_cmp u_hit (
      .cfg    (cmp_cfg[g]),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .hit    (hit_vec[g]),
      .row    (row_arr[g]),
      .col    (col_arr[g])
    );
  end

  // Scan from lowest priority upward so the lowest-index hitting slot is left as winner
  always_comb begin
    win_hit = 1'b0;
    win_id  = '0;
    win_row = '0;
    win_col = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win_hit = 1'b1;
        win_id  = spr_id_t'(i);
        win_row = row_arr[i];
        win_col = col_arr[i];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_id    <= '0;
      rom_addr <= '0;
    end else begin
      s1_valid <= pixel_en;
      s1_hit   <= pixel_en && win_hit;
      s1_id    <= win_id;
      rom_addr <= (pixel_en && win_hit) ? make_rom_addr(win_id, win_row, win_col) : '0;
    end
  end

  // A transparent winner stays transparent; lower-priority slots are never consulted
  assign fg_bit = s1_valid && s1_hit && rom_data;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_valid <= 1'b0;
      pixel_on    <= 1'b0;
      pixel_id    <= '0;
    end else begin
      pixel_valid <= s1_valid;
      pixel_on    <= fg_bit;
      pixel_id    <= fg_bit ? s1_id : '0;
    end
  end

endmodule
